fetch_stage_wide: RTL
=====================

Name: fetch_stage_wide

Overview:
- Parametrised successor to the single-issue fetch stage.
- Fetches an aligned block of FETCH_WIDTH instructions per memory request.
- Supports up to MAX_OUTSTANDING in-flight requests over a valid/ready request channel.
- Redirects are epoch-tagged, so stale responses are squashed. Fetch packets go to the instruction buffer and branch predictor over a valid/ready output channel.

Parameters:
XLEN, 32, address/PC width
FETCH_WIDTH, 2, instructions per fetch block (power of 2, >=1); block = FETCH_WIDTH*4 bytes
MAX_OUTSTANDING, 2, in-flight requests plus buffered responses (power of 2, >=1)
EPOCH_W, 2, redirect epoch tag width
RESET_PC, 0, PC after reset

Ports:
clock  in  1  sole clock
reset_n  in  1  one clock; reset is asynchronous and active-low
redirect_valid  in  1  branch/flush redirect, highest priority
redirect_pc  in  XLEN  redirect target (word aligned)
fetch_stall  in  1  suppress new requests
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  block-aligned address
imem_req_tag  out  EPOCH_W  current epoch
imem_rsp_valid  in  1  response valid (in order, always accepted)
imem_rsp_data  in  FETCH_WIDTH*32  block data, slot i = bits [32i+31:32i]
imem_rsp_tag  in  EPOCH_W  echoed epoch
out_valid  out  1  fetch packet valid
out_ready  in  1  consumer accepts packet
out_inst  out  FETCH_WIDTH*32  instructions, invalid slots = NOP
out_slot_valid  out  FETCH_WIDTH  per-slot valid mask
out_pc  out  XLEN  PC of first valid slot
out_npc  out  XLEN  block base + FETCH_WIDTH*4 (next sequential fetch PC)

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - PC=RESET_PC, epoch=0, credit count=0, response FIFO empty.
  - imem_req_valid=0, out_valid=0, out_slot_valid=0, out_inst=all NOP, out_pc=out_npc=0.
- Credits:
  - credit = in-flight + buffered entries; never exceeds MAX_OUTSTANDING.
  - +1 on request handshake; -1 on stale response drop or output handshake. Simultaneous +1/-1 leaves it unchanged.
- Request channel:
  - imem_req_valid = !redirect_valid && !fetch_stall && credit<MAX_OUTSTANDING.
  - addr = PC with low log2(FETCH_WIDTH*4) bits cleared.
  - Valid may drop without handshake only on redirect/stall; addr/tag stay stable while valid && !ready.
- Per request, push {PC, epoch} into an in-flight tracking queue of depth MAX_OUTSTANDING.
- On handshake, PC <= block base + FETCH_WIDTH*4, wrapping modulo 2^XLEN.
- Redirect (edge with redirect_valid=1):
  - PC=redirect_pc, epoch=epoch+1 (wraps).
  - Response FIFO flushed; its entries' credits are released.
  - In-flight entries stay counted until their responses return.
  - out_valid is forced 0 combinationally in the redirect cycle; no output handshake occurs that cycle.
  - Redirect beats stall, a pending request, and a simultaneous response.
- Responses:
  - Matched in order to the head of the tracking queue.
  - tag != current epoch (or entry issued in an old epoch): drop, credit-1.
  - Otherwise push into the response FIFO with the slot mask: slots with index < PC[log2(FETCH_WIDTH*4)-1:2] invalid.
  - A response arriving with an empty tracking queue is a protocol error (assertion).
- Output: head of the response FIFO, registered (no combinational path from imem_rsp_* to out_*).
  - Minimum latency: response edge -> out_valid the next cycle.
  - Held stable while out_valid && !out_ready.
- Boundaries:
  - FIFO full: cannot occur, because credits reserve space before issue.
  - Response arriving in the same cycle as an output handshake on a full FIFO is allowed.
  - fetch_stall does not block responses or output.
  - FETCH_WIDTH=1 degenerates to single-issue with an all-ones mask.
  - PC wrap at 2^XLEN-block is legal.

Decomposition:
- Shared package fetch_pkg:
  - NOP constant 32'h00000013.
  - FETCH_PKT typedef {inst, slot_valid, pc, npc}, parametrised by macros.
  - Epoch type.
- One natural sub-module: fetch_rsp_fifo.
  - Synchronous FIFO with flush, depth MAX_OUTSTANDING, async active-low reset.
  - Reused for the tracking queue and the response buffer.

Test Plan:
- Reset then ready=1, 1-cycle memory, out_ready=1, FW=2 -> requests 0x0,0x8,0x10...; packets pc=0x0 npc=0x8 mask=2'b11, continuous throughput.
- Redirect to 0x104 with 2 requests in flight -> both old-epoch responses dropped; next request addr=0x100 tag=1; packet mask=2'b10, slot0=NOP, pc=0x104.
- out_ready=0 for 10 cycles -> at most MAX_OUTSTANDING requests issued, imem_req_valid=0 afterward, packet held stable; release -> packets in order, none lost.
- fetch_stall=1 with imem_req_ready=0 pending -> req_valid drops; outstanding responses still delivered; deassert -> same addr reissued.
- Async reset_n pulse mid-burst (not clock aligned) -> all outputs zero/NOP immediately; first request after release addr=RESET_PC, tag=0.
- Redirect, response and output handshake in the same cycle -> response dropped, FIFO empty, out_valid=0 that cycle, credit count correct (assert never > MAX_OUTSTANDING).

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Package : fetch_pkg
// Shared constants and packet/epoch types for the wide fetch stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifndef FETCH_PKG_XLEN
`define FETCH_PKG_XLEN 32
`endif
`ifndef FETCH_PKG_FW
`define FETCH_PKG_FW 2
`endif
`ifndef FETCH_PKG_EPOCH_W
`define FETCH_PKG_EPOCH_W 2
`endif

package fetch_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [`FETCH_PKG_EPOCH_W-1:0] epoch_t;

    typedef struct packed {
        logic [`FETCH_PKG_FW*32-1:0] inst;
        logic [`FETCH_PKG_FW-1:0]    slot_valid;
        logic [`FETCH_PKG_XLEN-1:0]  pc;
        logic [`FETCH_PKG_XLEN-1:0]  npc;
    } fetch_pkt_t;

    function automatic logic [31:0] slot_or_nop(input logic valid, input logic [31:0] word);
        return valid ? word : NOP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_wide_if.sv
// ============================================================================
// Interface : fetch_stage_wide_if
// Instruction-memory request/response channels and fetch-packet output channel.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_wide_if #(
    parameter int XLEN        = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int EPOCH_W     = 2
);
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [XLEN-1:0]          imem_req_addr;
    logic [EPOCH_W-1:0]       imem_req_tag;
    logic                     imem_rsp_valid;
    logic [FETCH_WIDTH*32-1:0] imem_rsp_data;
    logic [EPOCH_W-1:0]       imem_rsp_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [FETCH_WIDTH*32-1:0] out_inst;
    logic [FETCH_WIDTH-1:0]   out_slot_valid;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_npc;

    modport master (
        output imem_req_valid, imem_req_addr, imem_req_tag,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_tag,
        output out_valid, out_inst, out_slot_valid, out_pc, out_npc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_req_tag,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_tag,
        input  out_valid, out_inst, out_slot_valid, out_pc, out_npc,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_rsp_fifo.sv
// ============================================================================
// Module : fetch_rsp_fifo
// Synchronous FIFO with flush; backs both in-flight tracking and response buffering.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_rsp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; an empty FIFO never exposes it as valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage_wide.sv
// ============================================================================
// Module : fetch_stage_wide
// Block-wide instruction fetch with credit-limited outstanding requests and epoch squash.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage_wide
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              FETCH_WIDTH     = 2,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              EPOCH_W         = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               fetch_stall,
    fetch_stage_wide_if.master bus
);

    localparam int BLOCK_BYTES = FETCH_WIDTH * 4;
    localparam int CW          = $clog2(MAX_OUTSTANDING + 1);
    localparam int TRK_W       = XLEN + EPOCH_W;
    localparam int PKT_W       = FETCH_WIDTH * 32 + FETCH_WIDTH + 2 * XLEN;

    logic [XLEN-1:0]           pc;
    logic [EPOCH_W-1:0]        epoch;
    logic [CW-1:0]             credit;
    logic [CW-1:0]             credit_rel;
    logic                      run;

    logic [XLEN-1:0]           pc_base;
    logic                      req_hs;
    logic                      out_hs;

    logic [TRK_W-1:0]          trk_head;
    logic                      trk_empty;
    logic [CW-1:0]             trk_count;
    logic [XLEN-1:0]           trk_pc;
    logic [EPOCH_W-1:0]        trk_epoch;
    logic [XLEN-1:0]           trk_base;

    logic                      rsp_stale;
    logic                      rsp_push;
    logic                      rsp_drop;
    logic [FETCH_WIDTH-1:0]    rsp_mask;
    logic [FETCH_WIDTH*32-1:0] rsp_inst;
    logic [XLEN-1:0]           rsp_npc;

    logic [PKT_W-1:0]          pkt_in;
    logic [PKT_W-1:0]          pkt_head;
    logic                      pkt_empty;
    logic [CW-1:0]             pkt_count;
    logic [FETCH_WIDTH*32-1:0] head_inst;
    logic [FETCH_WIDTH-1:0]    head_mask;
    logic [XLEN-1:0]           head_pc;
    logic [XLEN-1:0]           head_npc;

    // ---------------- request channel ----------------
    assign pc_base            = pc & ~XLEN'(BLOCK_BYTES - 1);
    assign bus.imem_req_valid = run && !redirect_valid && !fetch_stall
                                && (credit < CW'(MAX_OUTSTANDING));
    assign bus.imem_req_addr  = pc_base;
    assign bus.imem_req_tag   = epoch;
    assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

    fetch_rsp_fifo #(
        .WIDTH (TRK_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (1'b0),
        .push      (req_hs),
        .push_data ({pc, epoch}),
        .pop       (bus.imem_rsp_valid),
        .head      (trk_head),
        .empty     (trk_empty),
        .count     (trk_count)
    );

    // ---------------- response matching ----------------
    assign trk_pc    = trk_head[TRK_W-1:EPOCH_W];
    assign trk_epoch = trk_head[EPOCH_W-1:0];
    assign trk_base  = trk_pc & ~XLEN'(BLOCK_BYTES - 1);
    assign rsp_npc   = trk_base + XLEN'(BLOCK_BYTES);

    assign rsp_stale = redirect_valid || (bus.imem_rsp_tag != epoch) || (trk_epoch != epoch);
    assign rsp_push  = bus.imem_rsp_valid && !rsp_stale;
    assign rsp_drop  = bus.imem_rsp_valid && rsp_stale;

    // Slots before the word the PC points into belong to the previous path.
    if (FETCH_WIDTH == 1) begin : g_single
        assign rsp_mask = '1;
    end else begin : g_multi
        localparam int OFF_W = $clog2(FETCH_WIDTH);
        logic [OFF_W-1:0] first_slot;
        assign first_slot = trk_pc[OFF_W+1:2];
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_mask
            assign rsp_mask[i] = (OFF_W'(i) >= first_slot);
        end
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        assign rsp_inst[32*i +: 32] = slot_or_nop(rsp_mask[i], bus.imem_rsp_data[32*i +: 32]);
    end

    assign pkt_in = {rsp_inst, rsp_mask, trk_pc, rsp_npc};

    fetch_rsp_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pkt_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data (pkt_in),
        .pop       (out_hs),
        .head      (pkt_head),
        .empty     (pkt_empty),
        .count     (pkt_count)
    );

    // ---------------- output channel ----------------
    assign {head_inst, head_mask, head_pc, head_npc} = pkt_head;

    assign bus.out_valid      = !pkt_empty && !redirect_valid;
    assign bus.out_inst       = pkt_empty ? {FETCH_WIDTH{NOP}} : head_inst;
    assign bus.out_slot_valid = pkt_empty ? '0 : head_mask;
    assign bus.out_pc         = pkt_empty ? '0 : head_pc;
    assign bus.out_npc        = pkt_empty ? '0 : head_npc;
    assign out_hs             = bus.out_valid && bus.out_ready;

    // A redirect flushes the buffer, returning every buffered entry's credit at once.
    assign credit_rel = redirect_valid ? pkt_count : CW'(out_hs);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            epoch  <= '0;
            credit <= '0;
            run    <= 1'b0;
        end else begin
            run    <= 1'b1;
            credit <= credit + CW'(req_hs) - CW'(rsp_drop) - credit_rel;
            if (redirect_valid) begin
                pc    <= redirect_pc;
                epoch <= epoch + 1'b1;
            end else if (req_hs) begin
                pc <= pc_base + XLEN'(BLOCK_BYTES);
            end
        end
    end

    a_rsp_has_owner: assert property (@(posedge clock) disable iff (!reset_n)
        bus.imem_rsp_valid |-> !trk_empty);

    a_credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
        credit <= CW'(MAX_OUTSTANDING));

    a_credit_sum: assert property (@(posedge clock) disable iff (!reset_n)
        {1'b0, credit} == ((CW+1)'(trk_count) + (CW+1)'(pkt_count)));

endmodule

`default_nettype wire
